// File: rtl/fp24_pkg.sv
// Shared fp24 format definitions: field widths, exponent bias and the
// packed operand struct, plus small decode helpers used by the converter.
package fp24_pkg;

    localparam int FP24_EXP_W  = 7;
    localparam int FP24_MANT_W = 16;
    localparam int FP24_W      = 1 + FP24_EXP_W + FP24_MANT_W;
    localparam int FP24_BIAS   = 63;

    // Significand carries the hidden leading one above the stored mantissa.
    localparam int FP24_SIG_W  = FP24_MANT_W + 1;

    // Signed shift distance; covers every exponent after bias/point adjustment.
    localparam int SH_W        = 9;

    typedef struct packed {
        logic                   sign;
        logic [FP24_EXP_W-1:0]  exp;
        logic [FP24_MANT_W-1:0] mant;
    } fp24_t;

    // Restore the hidden one in front of the stored mantissa.
    function automatic logic [FP24_SIG_W-1:0] fp24_sig(input fp24_t f);
        return {1'b1, f.mant};
    endfunction

    // A biased exponent of zero encodes zero regardless of mantissa.
    function automatic logic fp24_is_zero(input fp24_t f);
        return (f.exp == {FP24_EXP_W{1'b0}});
    endfunction

endpackage

// File: rtl/fx_sat_shift.sv
// Combinational core of stage 2: aligns the significand to the output
// binary point, then saturates, flushes or negates into a W-bit result.
// The shifted magnitude is kept W+17 bits wide so that nothing is lost
// before the saturation compare; shifts past W are reported as huge directly.
module fx_sat_shift
    import fp24_pkg::*;
#(
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 16
) (
    input  logic [FP24_SIG_W-1:0]          sig,
    input  logic signed [SH_W-1:0]         sh,
    input  logic                           sign,
    output logic [INT_BITS+FRAC_BITS-1:0]  data,
    output logic                           ovf,
    output logic                           udf
);

    localparam int W     = INT_BITS + FRAC_BITS;
    localparam int MAG_W = W + FP24_SIG_W;

    localparam logic [MAG_W-1:0] LIM     = {{(MAG_W-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]     POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     NEG_MAX = {1'b1, {(W-1){1'b0}}};

    // Any left shift beyond W puts the leading one far past the sign bit.
    localparam logic signed [SH_W-1:0] SH_MAX = SH_W'(W);

    logic [MAG_W-1:0] sig_ext_s;
    logic [MAG_W-1:0] mag_s;
    logic [SH_W-1:0]  rsh_s;
    logic             huge_s;
    logic             sat_s;

    assign sig_ext_s = {{W{1'b0}}, sig};
    assign rsh_s     = -sh;

    // Align the significand: left shift for large exponents, truncating right shift otherwise.
    always_comb begin
        huge_s = 1'b0;
        mag_s  = {MAG_W{1'b0}};
        if (sh > SH_MAX) begin
            huge_s = 1'b1;
        end else if (!sh[SH_W-1]) begin
            mag_s = sig_ext_s << sh[SH_W-2:0];
        end else begin
            mag_s = sig_ext_s >> rsh_s;
        end
    end

    // Clamp out-of-range magnitudes, flag truncation to zero, otherwise apply the sign.
    always_comb begin
        data  = {W{1'b0}};
        ovf   = 1'b0;
        udf   = 1'b0;
        sat_s = huge_s || (sign ? (mag_s > LIM) : (mag_s >= LIM));
        if (sat_s) begin
            ovf  = 1'b1;
            data = sign ? NEG_MAX : POS_MAX;
        end else if (mag_s == {MAG_W{1'b0}}) begin
            udf  = 1'b1;
        end else begin
            // -2^(W-1) exactly lands here and negates to the most negative code.
            data = sign ? (-mag_s[W-1:0]) : mag_s[W-1:0];
        end
    end

endmodule

// File: rtl/fp24_to_fixed.sv
// Streaming fp24 -> signed fixed-point converter.
// Stage 1 registers the decoded operand (sign, significand, shift, zero);
// stage 2 registers the saturated/flushed result. Valid/ready on both sides,
// one result per cycle, two-cycle latency, and no bubble after a stall.
module fp24_to_fixed
    import fp24_pkg::*;
#(
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [FP24_W-1:0]              in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [INT_BITS+FRAC_BITS-1:0]  out_data,
    output logic                           out_ovf,
    output logic                           out_udf
);

    localparam int W = INT_BITS + FRAC_BITS;

    // Shift that moves the significand's binary point (16 fraction bits)
    // onto the output binary point, with the exponent bias folded in.
    localparam int SH_OFS = FRAC_BITS - FP24_MANT_W - FP24_BIAS;

    fp24_t                  in_fp_s;
    logic signed [SH_W-1:0] in_sh_s;

    logic                   s1_valid_r;
    logic                   s1_sign_r;
    logic [FP24_SIG_W-1:0]  s1_sig_r;
    logic signed [SH_W-1:0] s1_sh_r;
    logic                   s1_zero_r;

    logic                   out_valid_r;
    logic [W-1:0]           out_data_r;
    logic                   out_ovf_r;
    logic                   out_udf_r;

    logic                   s1_en_s;
    logic                   s2_en_s;

    logic [W-1:0]           sh_data_s;
    logic                   sh_ovf_s;
    logic                   sh_udf_s;
    logic [W-1:0]           s2_data_s;
    logic                   s2_ovf_s;
    logic                   s2_udf_s;

    assign in_fp_s = in_data;
    assign in_sh_s = $signed({{(SH_W-FP24_EXP_W){1'b0}}, in_fp_s.exp}) + SH_W'(SH_OFS);

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_en_s  = !out_valid_r || out_ready;
    assign s1_en_s  = !s1_valid_r || s2_en_s;
    assign in_ready = s1_en_s;

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ovf   = out_ovf_r;
    assign out_udf   = out_udf_r;

    fx_sat_shift #(
        .INT_BITS  (INT_BITS),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat_shift (
        .sig  (s1_sig_r),
        .sh   (s1_sh_r),
        .sign (s1_sign_r),
        .data (sh_data_s),
        .ovf  (sh_ovf_s),
        .udf  (sh_udf_s)
    );

    // Zero operands bypass the shifter so they never report underflow.
    always_comb begin
        s2_data_s = {W{1'b0}};
        s2_ovf_s  = 1'b0;
        s2_udf_s  = 1'b0;
        if (s1_zero_r) begin
            s2_data_s = {W{1'b0}};
            s2_ovf_s  = 1'b0;
            s2_udf_s  = 1'b0;
        end else begin
            s2_data_s = sh_data_s;
            s2_ovf_s  = sh_ovf_s;
            s2_udf_s  = sh_udf_s;
        end
    end

    // Stage 1 register: decode the accepted operand.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_sig_r   <= {FP24_SIG_W{1'b0}};
            s1_sh_r    <= {SH_W{1'b0}};
            s1_zero_r  <= 1'b0;
        end else if (s1_en_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_sign_r <= in_fp_s.sign;
                s1_sig_r  <= fp24_sig(in_fp_s);
                s1_sh_r   <= in_sh_s;
                s1_zero_r <= fp24_is_zero(in_fp_s);
            end
        end
    end

    // Stage 2 register: hold the converted result until the consumer takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
            out_ovf_r   <= 1'b0;
            out_udf_r   <= 1'b0;
        end else if (s2_en_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_data_r <= s2_data_s;
                out_ovf_r  <= s2_ovf_s;
                out_udf_r  <= s2_udf_s;
            end
        end
    end

endmodule

// File: tb/tb_fp24_to_fixed.sv
// Directed + random bench for fp24_to_fixed with a queue scoreboard.
// Expected results are pushed when an input is accepted and popped when an
// output transfers; all sampling happens on the falling clock edge.
module tb_fp24_to_fixed;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_udf;

    int          checks   = 0;
    int          failures = 0;
    int          n_out    = 0;
    logic [33:0] sb[$];
    logic [33:0] cur_exp;
    logic        acc_smp;
    logic        ov_smp;
    logic [31:0] od_smp;

    always #5 clk = ~clk;

    fp24_to_fixed #(.INT_BITS(16), .FRAC_BITS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_udf   (out_udf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Real-number reference: {data, ovf, udf} for 16.16 output.
    function automatic logic [33:0] model(input logic [23:0] d);
        logic        s;
        int          e;
        real         mr;
        real         mf;
        longint      lm;
        longint      v;
        logic [63:0] vb;
        s = d[23];
        e = int'(d[22:16]);
        if (e == 0) return 34'h0;
        mr = real'(65536 + int'(d[15:0])) * $pow(2.0, real'(e - 63));
        mf = $floor(mr);
        if (!s && mf >= 2147483648.0) return {32'h7FFF_FFFF, 1'b1, 1'b0};
        if (s && mf > 2147483648.0)   return {32'h8000_0000, 1'b1, 1'b0};
        if (mf == 0.0)                return {32'h0, 1'b0, 1'b1};
        lm = longint'(mf);
        v  = s ? -lm : lm;
        vb = v;
        return {vb[31:0], 1'b0, 1'b0};
    endfunction

    // One clock: sample at negedge, score any output transfer, record any accept.
    task automatic tick();
        logic [33:0] e;
        @(negedge clk);
        acc_smp = in_valid && in_ready;
        ov_smp  = out_valid;
        od_smp  = out_data;
        if (rst && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_out observed=%h expected=none", out_data);
                end
            end else begin
                e = sb.pop_front();
                check("out", {30'h0, out_data, out_ovf, out_udf}, {30'h0, e});
            end
        end
        if (acc_smp) sb.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] d, input logic [33:0] e, input logic rnd);
        in_valid = 1'b1;
        in_data  = d;
        cur_exp  = e;
        for (int i = 0; i < 200; i++) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (acc_smp) break;
        end
        check("accept", {63'h0, acc_smp}, 64'h1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("drain_empty", 64'(sb.size()), 64'h0);
    endtask

    logic [23:0] dvec[10];
    logic [33:0] evec[10];
    logic [23:0] bp[5];
    logic [31:0] ref_data;
    logic        have_ref;
    int          idx;
    int          t0;

    initial begin
        dvec[0] = 24'h3F0000; evec[0] = {32'h0001_0000, 2'b00};  // 1.0
        dvec[1] = 24'hC04000; evec[1] = {32'hFFFD_8000, 2'b00};  // -2.5
        dvec[2] = 24'h4E0000; evec[2] = {32'h7FFF_FFFF, 2'b10};  // +32768
        dvec[3] = 24'hCE0000; evec[3] = {32'h8000_0000, 2'b00};  // -32768 exact
        dvec[4] = 24'hCF0000; evec[4] = {32'h8000_0000, 2'b10};  // -65536
        dvec[5] = 24'h2F0000; evec[5] = {32'h0000_0001, 2'b00};  // 2^-16
        dvec[6] = 24'h2E0000; evec[6] = {32'h0000_0000, 2'b01};  // 2^-17
        dvec[7] = 24'h00FFFF; evec[7] = {32'h0000_0000, 2'b00};  // zero
        dvec[8] = 24'hAF8000; evec[8] = {32'hFFFF_FFFF, 2'b00};  // -1.5*2^-16 truncates
        dvec[9] = 24'h7F1234; evec[9] = {32'h7FFF_FFFF, 2'b10};  // max exponent

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 24'h0;
        out_ready = 1'b1;
        cur_exp   = 34'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_out_data",  {32'h0, out_data}, 64'h0);
        check("rst_out_ovf",   {63'h0, out_ovf}, 64'h0);
        check("rst_out_udf",   {63'h0, out_udf}, 64'h0);
        check("rst_in_ready",  {63'h0, in_ready}, 64'h1);
        rst = 1'b1;
        tick();

        // Latency: out_valid appears exactly two edges after the accepting edge.
        in_valid = 1'b1; in_data = dvec[0]; cur_exp = evec[0];
        tick();
        check("lat_accept", {63'h0, acc_smp}, 64'h1);
        in_valid = 1'b0;
        tick();
        check("lat_cycle1", {63'h0, ov_smp}, 64'h0);
        tick();
        check("lat_cycle2", {63'h0, ov_smp}, 64'h1);
        drain();

        // Directed values streamed back-to-back.
        for (int i = 1; i < 10; i++) send(dvec[i], evec[i], 1'b0);
        drain();

        // Backpressure: consumer stalled, five inputs offered.
        for (int i = 0; i < 5; i++) bp[i] = {1'b0, 7'(64 + i), 16'(i * 4099)};
        out_ready = 1'b0;
        idx = 0;
        have_ref = 1'b0;
        ref_data = 32'h0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_data = bp[idx]; cur_exp = model(bp[idx]);
            tick();
            if (acc_smp) idx++;
            if (ov_smp) begin
                if (have_ref) check("bp_stable", {32'h0, od_smp}, {32'h0, ref_data});
                else begin ref_data = od_smp; have_ref = 1'b1; end
            end
        end
        check("bp_accepted", 64'(idx), 64'h2);
        check("bp_in_ready", {63'h0, in_ready}, 64'h0);
        out_ready = 1'b1;
        t0 = n_out;
        for (int c = 0; c < 5; c++) begin
            if (idx < 5) begin
                in_valid = 1'b1; in_data = bp[idx]; cur_exp = model(bp[idx]);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (acc_smp) idx++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 64'(idx), 64'h5);
        check("bp_out_count", 64'(n_out - t0), 64'h5);
        check("bp_sb_empty", 64'(sb.size()), 64'h0);

        // Random operands against the real-number model, random consumer stalls.
        for (int n = 0; n < 10000; n++) begin
            logic [23:0] d;
            logic [6:0]  e;
            d = 24'($urandom);
            if ($urandom_range(0, 9) == 0) e = 7'($urandom_range(0, 127));
            else e = 7'($urandom_range(40, 80));
            d[22:16] = e;
            send(d, model(d), 1'b1);
        end
        drain();

        // Reset mid-stream with the pipe full.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = dvec[2]; cur_exp = evec[2];
        repeat (3) tick();
        check("pre_rst_full", {63'h0, out_valid}, 64'h1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("mid_rst_out_data",  {32'h0, out_data}, 64'h0);
        check("mid_rst_out_ovf",   {63'h0, out_ovf}, 64'h0);
        check("mid_rst_in_ready",  {63'h0, in_ready}, 64'h1);
        sb.delete();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        t0 = n_out;
        in_valid = 1'b1; in_data = dvec[1]; cur_exp = evec[1];
        tick();
        check("post_rst_accept", {63'h0, acc_smp}, 64'h1);
        in_valid = 1'b0;
        tick();
        check("post_rst_cycle1", {63'h0, ov_smp}, 64'h0);
        tick();
        check("post_rst_cycle2", {63'h0, ov_smp}, 64'h1);
        repeat (3) tick();
        check("post_rst_count", 64'(n_out - t0), 64'h1);
        check("final_sb_empty", 64'(sb.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
